// File: rtl/bist_march_if.sv
// SRAM-side bus of the March C- BIST engine: launch control, SRAM address/data/
// write-enable, read-back data and the per-read compare result.
interface bist_march_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) ();
    logic              start;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic              sram_we;
    logic [DATA_W-1:0] sram_dout;
    logic              busy;
    logic              done;
    logic              mismatch;
    logic [ADDR_W-1:0] fail_addr;

    modport master (
        input  start, sram_dout,
        output sram_addr, sram_din, sram_we, busy, done, mismatch, fail_addr
    );

    modport slave (
        output start, sram_dout,
        input  sram_addr, sram_din, sram_we, busy, done, mismatch, fail_addr
    );
endinterface

// File: rtl/bist_march_engine.sv
// March C- BIST engine: one SRAM op per cycle, registered read-compare two
// cycles behind the read, then a two-cycle drain before reporting done.
module bist_march_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bist_march_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0, S_M0 = 4'd1, S_M1 = 4'd2, S_M2 = 4'd3, S_M3 = 4'd4,
        S_M4    = 4'd5, S_M5 = 4'd6, S_DRAIN = 4'd7, S_DONE = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ONES = {DATA_W{1'b1}};

    function automatic logic is_march(input state_t s);
        return (s == S_M0) || (s == S_M1) || (s == S_M2) ||
               (s == S_M3) || (s == S_M4) || (s == S_M5);
    endfunction

    function automatic logic is_down(input state_t s);
        return (s == S_M3) || (s == S_M4);
    endfunction

    // Single-op elements finish an address in one cycle; the rest after the write.
    function automatic logic last_op(input state_t s, input logic ph);
        return (s == S_M0) || (s == S_M5) || ph;
    endfunction

    function automatic logic op_we(input state_t s, input logic ph);
        logic we;
        case (s)
            S_M0:    we = 1'b1;
            S_M5:    we = 1'b0;
            default: we = ph;
        endcase
        return we;
    endfunction

    // Background of the op: r0/w1 elements go 0 then 1, r1/w0 elements 1 then 0.
    function automatic logic op_one(input state_t s, input logic ph);
        logic one;
        case (s)
            S_M1, S_M3: one = ph;
            S_M2, S_M4: one = ~ph;
            default:    one = 1'b0;
        endcase
        return one;
    endfunction

    function automatic state_t next_elem(input state_t s);
        state_t n;
        case (s)
            S_M0:    n = S_M1;
            S_M1:    n = S_M2;
            S_M2:    n = S_M3;
            S_M3:    n = S_M4;
            S_M4:    n = S_M5;
            default: n = S_DRAIN;
        endcase
        return n;
    endfunction

    state_t            state_r, nxt_state_s;
    logic [ADDR_W-1:0] addr_r, nxt_addr_s, cmp_addr_r, fail_addr_r;
    logic              ph_r, nxt_ph_s, drain_r, busy_r, done_r;
    logic              we_r, rd_r, cmp_vld_r, mismatch_r, launch_s, mm_s;
    logic [DATA_W-1:0] din_r, exp_r, cmp_exp_r, nxt_data_s;

    assign launch_s   = ((state_r == S_IDLE) || (state_r == S_DONE)) && bus.start;
    assign mm_s       = cmp_vld_r && (bus.sram_dout != cmp_exp_r);
    assign nxt_data_s = op_one(nxt_state_s, nxt_ph_s) ? DATA_ONES : DATA_ZERO;

    // Next op: finish the address, then step it, then move to the next element.
    always_comb begin
        nxt_state_s = state_r;
        nxt_addr_s  = addr_r;
        nxt_ph_s    = ph_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (launch_s) begin
                    nxt_state_s = S_M0;
                    nxt_addr_s  = ADDR_ZERO;
                    nxt_ph_s    = 1'b0;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            S_DRAIN: begin
                if (drain_r) begin
                    nxt_state_s = S_DONE;
                end else begin
                    nxt_state_s = S_DRAIN;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (!last_op(state_r, ph_r)) begin
                    nxt_ph_s = 1'b1;
                end else if (addr_r == (is_down(state_r) ? ADDR_ZERO : ADDR_MAX)) begin
                    nxt_state_s = next_elem(state_r);
                    nxt_addr_s  = is_down(next_elem(state_r)) ? ADDR_MAX : ADDR_ZERO;
                    nxt_ph_s    = 1'b0;
                end else begin
                    nxt_addr_s  = is_down(state_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                    nxt_ph_s    = 1'b0;
                end
            end
            default: nxt_state_s = S_IDLE;
        endcase
    end

    // Sequencer state and the registered SRAM op with its expected background.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            addr_r  <= ADDR_ZERO;
            ph_r    <= 1'b0;
            drain_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            we_r    <= 1'b0;
            rd_r    <= 1'b0;
            din_r   <= DATA_ZERO;
            exp_r   <= DATA_ZERO;
        end else begin
            state_r <= nxt_state_s;
            addr_r  <= nxt_addr_s;
            ph_r    <= nxt_ph_s;
            drain_r <= (state_r == S_DRAIN) && !drain_r;
            busy_r  <= is_march(nxt_state_s) || (nxt_state_s == S_DRAIN);
            done_r  <= (nxt_state_s == S_DONE);
            if (is_march(nxt_state_s)) begin
                we_r  <= op_we(nxt_state_s, nxt_ph_s);
                rd_r  <= ~op_we(nxt_state_s, nxt_ph_s);
                din_r <= op_we(nxt_state_s, nxt_ph_s) ? nxt_data_s : DATA_ZERO;
                exp_r <= nxt_data_s;
            end else begin
                we_r  <= 1'b0;
                rd_r  <= 1'b0;
                din_r <= DATA_ZERO;
                exp_r <= DATA_ZERO;
            end
        end
    end

    // Compare pipeline: read data arrives one cycle after issue, result one later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_vld_r   <= 1'b0;
            cmp_exp_r   <= DATA_ZERO;
            cmp_addr_r  <= ADDR_ZERO;
            mismatch_r  <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
        end else if (launch_s) begin
            cmp_vld_r   <= 1'b0;
            cmp_exp_r   <= DATA_ZERO;
            cmp_addr_r  <= ADDR_ZERO;
            mismatch_r  <= 1'b0;
            fail_addr_r <= fail_addr_r;
        end else begin
            cmp_vld_r   <= rd_r;
            cmp_exp_r   <= exp_r;
            cmp_addr_r  <= addr_r;
            mismatch_r  <= mm_s;
            fail_addr_r <= mm_s ? cmp_addr_r : fail_addr_r;
        end
    end

    assign bus.sram_addr = addr_r;
    assign bus.sram_din  = din_r;
    assign bus.sram_we   = we_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.mismatch  = mismatch_r;
    assign bus.fail_addr = fail_addr_r;
endmodule

// File: tb/tb_bist_march_engine.sv
// Bench for bist_march_engine: SRAM model with injectable stuck-at faults and a
// March C- op list built from the algorithm description.
module tb_bist_march_engine;
    localparam int AW   = 8;
    localparam int DW   = 4;
    localparam int NOPS = 2560;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bist_march_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    bist_march_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference op list: element table -> (addr, we, data) per op cycle.
    logic [AW-1:0] ea [NOPS];
    logic          ew [NOPS];
    logic [DW-1:0] ed [NOPS];
    int el_down [6]    = '{0, 0, 0, 1, 1, 0};
    int el_nops [6]    = '{1, 2, 2, 2, 2, 1};
    int el_we   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    int el_one  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    task automatic build_ops();
        int k = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < 256; i++)
                for (int o = 0; o < el_nops[e]; o++) begin
                    ea[k] = (el_down[e] != 0) ? AW'(255 - i) : AW'(i);
                    ew[k] = (el_we[e][o] != 0);
                    ed[k] = (el_one[e][o] != 0) ? 4'hF : 4'h0;
                    k++;
                end
    endtask

    // SRAM model with one faulty cell (stuck bits forced on read).
    logic [DW-1:0] mem [256];
    logic          fault_en = 1'b0;
    logic [AW-1:0] fa  = 8'h00;
    logic [DW-1:0] sa0 = 4'h0;
    logic [DW-1:0] sa1 = 4'h0;
    logic          sticky;

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem[a];
        if (fault_en && a == fa) v = (v & ~sa0) | sa1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
        else bus.sram_dout <= rd_val(bus.sram_addr);
    end

    always @(posedge clk) begin
        if (!rst_n) sticky <= 1'b0;
        else if (bus.mismatch) sticky <= 1'b1;
    end

    // A read of a correctly written cell returns the background unless its stuck bits disagree.
    function automatic logic exp_mm(input int k);
        int j = k - 2;
        if (j < 0 || j >= NOPS) return 1'b0;
        if (ew[j] || !fault_en || ea[j] != fa) return 1'b0;
        return ((ed[j] & ~sa0) | sa1) != ed[j];
    endfunction

    int mm_cnt, first_mm, last_mm, busy_cnt;

    task automatic reset_seq();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_out", {bus.sram_addr, bus.sram_din, bus.sram_we, bus.busy, bus.done,
                             bus.mismatch, bus.fail_addr}, 32'h0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_idle", {bus.busy, bus.done, bus.mismatch, bus.sram_we}, 32'h0);
        end
    endtask

    // Launch from IDLE/DONE (called just after a negedge) and check every cycle.
    task automatic run_march(input int rst_at, input bit pulses);
        logic em;
        mm_cnt = 0; first_mm = -1; last_mm = -1; busy_cnt = 0;
        bus.start = 1'b1;
        for (int k = 0; k <= NOPS + 2; k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            if (k < NOPS)
                check_eq("op", {bus.busy, bus.done, bus.sram_addr, bus.sram_we, bus.sram_din},
                         {1'b1, 1'b0, ea[k], ew[k], (ew[k] ? ed[k] : 4'h0)});
            else if (k < NOPS + 2)
                check_eq("drain", {bus.busy, bus.done, bus.sram_we}, {1'b1, 1'b0, 1'b0});
            else
                check_eq("done", {bus.busy, bus.done, bus.sram_we}, {1'b0, 1'b1, 1'b0});
            em = exp_mm(k);
            check_eq("mismatch", bus.mismatch, em);
            if (em) check_eq("fail_addr", bus.fail_addr, ea[k-2]);
            if (bus.mismatch) begin
                mm_cnt++;
                if (first_mm < 0) first_mm = k;
                last_mm = k;
            end
            if (bus.busy) busy_cnt++;
            if (k == rst_at) begin
                reset_seq();
                return;
            end
            if (pulses && (k == 10 || k == NOPS)) bus.start = 1'b1;
            else if (pulses && (k == 11 || k == NOPS + 1)) bus.start = 1'b0;
        end
        check_eq("busy_cycles", busy_cnt, 2562);
    endtask

    task automatic rand_fault();
        logic [DW-1:0] m;
        m = DW'($urandom_range(1, 15));
        fault_en = 1'b1;
        fa = AW'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) begin sa1 = m; sa0 = 4'h0; end
        else begin sa0 = m; sa1 = 4'h0; end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        build_ops();
        repeat (2) @(negedge clk);
        reset_seq();

        // Fault-free run: no mismatch, sticky flag stays clear.
        run_march(-1, 1'b0);
        check_eq("ff_mm_cnt", mm_cnt, 0);
        check_eq("ff_sticky", sticky, 1'b0);

        // Bit0 stuck-at-1 at 0x37, with ignored start pulses at k=10 and in DRAIN.
        fault_en = 1'b1; fa = 8'h37; sa1 = 4'h1; sa0 = 4'h0;
        run_march(-1, 1'b1);
        check_eq("sa1_cnt", mm_cnt, 3);
        check_eq("sa1_first", first_mm, 368);
        check_eq("sa1_faddr", bus.fail_addr, 8'h37);
        check_eq("sa1_sticky", sticky, 1'b1);

        // Relaunch straight out of DONE; fault in the last M5 read lands during DRAIN.
        fa = 8'hFF; sa1 = 4'h2; sa0 = 4'h0;
        run_march(-1, 1'b0);
        check_eq("last_mm", last_mm, NOPS + 1);

        // Reset at k=900 with a read of a faulty cell in flight, then a full run.
        fa = 8'd66; sa0 = 4'h1; sa1 = 4'h0;
        run_march(900, 1'b0);
        check_eq("rst_faddr", bus.fail_addr, 8'h00);
        run_march(-1, 1'b0);
        check_eq("sa0_cnt", mm_cnt, 2);

        // Random faults and a random reset point.
        for (int r = 0; r < 2; r++) begin
            rand_fault();
            run_march($urandom_range(3, 2500), 1'b0);
            rand_fault();
            run_march(-1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
